// File: rtl/fsm_steer.sv
// Input-side steering driver for the 8-state, 2-bit-input FSM family.
// Issues shortest-path input symbols toward a requested state and lockstep-checks the driven FSM.
module fsm_steer #(
  parameter int         MAX_STEPS = 7,
  parameter logic [2:0] S7_CODE   = 3'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_target,
  output logic [1:0] a_out,
  output logic       step_en,
  input  logic [2:0] s_obs,
  output logic       done,
  output logic [3:0] steps,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, STEER, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] model, target, succ;
  logic       hit, abort, mismatch;

  // Transition table of the driven FSM, indexed [state][symbol].
  function automatic logic [2:0] succ_f(input logic [2:0] m, input logic [1:0] a);
    logic [3:0][2:0] row;
    case (m)
      3'd0:    row = {3'd5, 3'd1, 3'd3, 3'd1};
      3'd1:    row = {3'd5, 3'd7, 3'd3, 3'd2};
      3'd2:    row = {3'd5, 3'd3, 3'd4, 3'd0};
      3'd3:    row = {3'd5, 3'd1, 3'd2, 3'd0};
      3'd4:    row = {3'd5, 3'd1, 3'd3, 3'd0};
      3'd5:    row = {3'd6, 3'd1, 3'd3, 3'd0};
      3'd6:    row = {3'd7, 3'd1, 3'd3, 3'd0};
      default: row = {3'd5, 3'd2, 3'd3, 3'd0};
    endcase
    return row[a];
  endfunction

  // First symbol on a shortest path [state][target]; ties resolved to the lowest symbol.
  function automatic logic [1:0] hop_f(input logic [2:0] m, input logic [2:0] t);
    logic [7:0][1:0] row;
    case (m)
      3'd0:    row = {2'd0, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
      3'd1:    row = {2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
      3'd2:    row = {2'd0, 2'd3, 2'd3, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
      3'd3:    row = {2'd2, 2'd3, 2'd3, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
      3'd4:    row = {2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
      3'd5:    row = {2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
      3'd6:    row = {2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
      default: row = {2'd0, 2'd3, 2'd3, 2'd2, 2'd1, 2'd2, 2'd0, 2'd0};
    endcase
    return row[t];
  endfunction

  function automatic logic [2:0] f_obs(input logic [2:0] m);
    return (m == 3'd7) ? S7_CODE : m;
  endfunction

  assign succ     = succ_f(model, a_out);
  assign hit      = (succ == target);
  assign abort    = ((steps + 4'd1) == 4'(MAX_STEPS));
  assign mismatch = (s_obs != f_obs(model));

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    step_en   = 1'b0;
    a_out     = 2'd0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (req_target == model) ? DONE : STEER;
      end
      STEER: begin
        step_en = 1'b1;
        a_out   = hop_f(model, target);
        if (hit || abort) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      model  <= 3'd0;
      target <= 3'd0;
      steps  <= 4'd0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mismatch) err <= 1'b1;
      case (state)
        IDLE: if (req_valid) begin
          target <= req_target;
          steps  <= 4'd0;
        end
        STEER: begin
          model <= succ;
          steps <= steps + 4'd1;
          // Success on the final permitted step is not an abort.
          if (!hit && abort) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_steer.sv
// Directed bench for fsm_steer: two instances (default and MAX_STEPS=1), each driving a behavioural FSM.
module tb_fsm_steer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic       rst_a, vld_a, rdy_a, stp_a, done_a, err_a;
  logic [2:0] tgt_a, obs_a, fsm_a;
  logic [1:0] a_a;
  logic [3:0] steps_a;

  logic       rst_b, vld_b, rdy_b, stp_b, done_b, err_b;
  logic [2:0] tgt_b, obs_b, fsm_b;
  logic [1:0] a_b;
  logic [3:0] steps_b;

  logic       ovr;
  logic [2:0] ovr_val;

  fsm_steer dut (
    .clk(clk), .reset(rst_a), .req_valid(vld_a), .req_ready(rdy_a), .req_target(tgt_a),
    .a_out(a_a), .step_en(stp_a), .s_obs(obs_a), .done(done_a), .steps(steps_a), .err(err_a)
  );

  fsm_steer #(.MAX_STEPS(1)) dut1 (
    .clk(clk), .reset(rst_b), .req_valid(vld_b), .req_ready(rdy_b), .req_target(tgt_b),
    .a_out(a_b), .step_en(stp_b), .s_obs(obs_b), .done(done_b), .steps(steps_b), .err(err_b)
  );

  function automatic logic [2:0] nxt(input logic [2:0] s, input logic [1:0] a);
    int row[4];
    case (s)
      3'd0:    row = '{1, 3, 1, 5};
      3'd1:    row = '{2, 3, 7, 5};
      3'd2:    row = '{0, 4, 3, 5};
      3'd3:    row = '{0, 2, 1, 5};
      3'd4:    row = '{0, 3, 1, 5};
      3'd5:    row = '{0, 3, 1, 6};
      3'd6:    row = '{0, 3, 1, 7};
      default: row = '{0, 3, 2, 5};
    endcase
    return 3'(row[a]);
  endfunction

  function automatic logic [2:0] fobs(input logic [2:0] m);
    return (m == 3'd7) ? 3'd3 : m;
  endfunction

  // Driven FSMs, clock-enabled by each DUT's step_en.
  always @(posedge clk) begin
    if (!rst_a) fsm_a <= 3'd0;
    else if (stp_a) fsm_a <= nxt(fsm_a, a_a);
    if (!rst_b) fsm_b <= 3'd0;
    else if (stp_b) fsm_b <= nxt(fsm_b, a_b);
  end

  assign obs_a = ovr ? ovr_val : fobs(fsm_a);
  assign obs_b = fobs(fsm_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request on the default instance; seq[0] is the first symbol expected.
  task automatic req_a(input string tag, input logic [2:0] t, input int n,
                       input logic [3:0][1:0] seq, input logic e);
    check({tag, "/rdy"}, rdy_a, 1);
    vld_a = 1'b1;
    tgt_a = t;
    @(negedge clk);
    vld_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s/step_en%0d", tag, i), stp_a, 1);
      check($sformatf("%s/busy%0d", tag, i), rdy_a, 0);
      check($sformatf("%s/a%0d", tag, i), a_a, seq[i]);
      @(negedge clk);
    end
    check({tag, "/done"}, done_a, 1);
    check({tag, "/step_off"}, stp_a, 0);
    check({tag, "/steps"}, steps_a, n);
    check({tag, "/obs"}, obs_a, fobs(t));
    check({tag, "/err"}, err_a, e);
    @(negedge clk);
    check({tag, "/done_clr"}, done_a, 0);
    check({tag, "/idle"}, rdy_a, 1);
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0;
    tgt_a = 3'd0; tgt_b = 3'd0;
    ovr = 1'b0; ovr_val = 3'd0;
    repeat (2) @(negedge clk);
    check("rst/rdy", rdy_a, 1);
    check("rst/step_en", stp_a, 0);
    check("rst/a_out", a_a, 0);
    check("rst/steps", steps_a, 0);
    check("rst/err", err_a, 0);
    check("rst/done", done_a, 0);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    req_a("0to4", 3'd4, 3, {2'd0, 2'd1, 2'd0, 2'd0}, 1'b0);
    req_a("4to6", 3'd6, 2, {2'd0, 2'd0, 2'd3, 2'd3}, 1'b0);
    req_a("6to7", 3'd7, 1, {2'd0, 2'd0, 2'd0, 2'd3}, 1'b0);
    req_a("7to7", 3'd7, 0, '0, 1'b0);
    req_a("7to1", 3'd1, 2, {2'd0, 2'd0, 2'd0, 2'd0}, 1'b0);

    // Corrupt the observed output while the model sits at 1.
    ovr = 1'b1; ovr_val = 3'd5;
    @(negedge clk);
    ovr = 1'b0;
    check("lock/err_set", err_a, 1);
    req_a("1to3", 3'd3, 1, {2'd0, 2'd0, 2'd0, 2'd1}, 1'b1);
    check("lock/sticky", err_a, 1);
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    check("lock/err_clr", err_a, 0);
    check("lock/steps_clr", steps_a, 0);

    // MAX_STEPS=1 instance: abort after a single step.
    check("max/rdy", rdy_b, 1);
    vld_b = 1'b1; tgt_b = 3'd4;
    @(negedge clk);
    vld_b = 1'b0;
    check("max/step_en", stp_b, 1);
    check("max/a0", a_b, 0);
    @(negedge clk);
    check("max/done", done_b, 1);
    check("max/steps", steps_b, 1);
    check("max/err", err_b, 1);
    check("max/obs", obs_b, 1);
    @(negedge clk);
    check("max/idle", rdy_b, 1);

    // Reset in the middle of a later request.
    vld_b = 1'b1; tgt_b = 3'd4;
    @(negedge clk);
    vld_b = 1'b0;
    check("mid/step_en", stp_b, 1);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check("mid/rdy", rdy_b, 1);
    check("mid/step_off", stp_b, 0);
    check("mid/done", done_b, 0);
    check("mid/steps", steps_b, 0);
    check("mid/err", err_b, 0);

    // Model back at 0: target 1 is one a=0 step and completes without abort.
    vld_b = 1'b1; tgt_b = 3'd1;
    @(negedge clk);
    vld_b = 1'b0;
    check("post/a0", a_b, 0);
    @(negedge clk);
    check("post/done", done_b, 1);
    check("post/steps", steps_b, 1);
    check("post/err", err_b, 0);
    check("post/obs", obs_b, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_steer.md
Name: fsm_steer

Overview:
- Input-side driver for the 3-bit, 2-bit-input state machine (`statem`/`statePorta`/`stateMem` family).
- Accepts a target state over a valid/ready handshake and emits the shortest sequence of input symbols `a[1:0]` that moves the driven FSM from its current state to the target.
- Runs an internal lockstep model of the driven FSM and checks that model against the FSM's observed output.
- Sits between a test or control sequencer and a driven FSM instance whose clock enable is `step_en`.

Parameters:
- MAX_STEPS, 7, abort threshold: steps per request before `err` is set and the request terminates.
- S7_CODE, 3, observed output code produced by state 7 (the driven FSM outputs 3 for state 7).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  target request valid.
- req_ready  out  1  high only in IDLE.
- req_target  in  3  requested destination state, 0..7.
- a_out  out  2  input symbol to the driven FSM.
- step_en  out  1  driven FSM advances on a clk edge only when step_en=1.
- s_obs  in  3  output of the driven FSM.
- done  out  1  one-cycle pulse at request completion.
- steps  out  4  symbols issued for the current/last request; held until next accept.
- err  out  1  sticky error flag.

Behaviour:
- Transition table, next state for a=0/1/2/3:
  - 0: 1/3/1/5
  - 1: 2/3/7/5
  - 2: 0/4/3/5
  - 3: 0/2/1/5
  - 4: 0/3/1/5
  - 5: 0/3/1/6
  - 6: 0/3/1/7
  - 7: 0/3/2/5
- Expected output f(m) = m for m≠7; f(7) = S7_CODE.
- Next hop hop(m,t): the a that minimises the distance from succ(m,a) to t. Ties go to the lowest a. Implement as a 64-entry constant table; the graph is strongly connected.
- Reset (reset=0 at a rising edge):
  - State=IDLE, model=0, target reg=0, steps=0, err=0, done=0.
  - Outputs: req_ready=1, step_en=0, a_out=00.
  - Reset mid-STEER abandons the request; the driven FSM must be reset in the same cycle.
- IDLE:
  - req_ready=1, step_en=0, a_out=00.
  - On req_valid at an edge: latch req_target and clear steps.
  - If target == model, go to DONE (zero steps). Otherwise go to STEER.
- STEER:
  - req_ready=0, step_en=1, a_out=hop(model,target), combinational from registered model and target.
  - Each edge: model<=succ(model,a_out); steps<=steps+1.
  - If succ == target, go to DONE.
  - Else if steps+1 == MAX_STEPS, set err and go to DONE.
- DONE: one cycle, done=1, step_en=0, req_ready=0; then IDLE.
- req_valid outside IDLE is ignored; the requester holds it until req_ready.
- Lockstep check:
  - Every cycle after reset, compare s_obs with f(model).
  - A mismatch sets err at the next edge; err clears only on reset.
  - Steering continues on the model regardless.
- Latency:
  - accept → DONE pulse = d+1 cycles, where d = shortest distance.
  - Zero-distance request: done on the cycle after accept.
  - Back-to-back requests: one IDLE cycle minimum between them.

Test Plan:
- Reset, then target 4 from 0 → a_out sequence 0,0,1 on consecutive step_en cycles; model 1,2,4; done pulse; steps=3; s_obs follows 1,2,4; err=0.
- From 4, target 6 → a_out 3,3 (4→5→6); steps=2; done.
- From 6, target 7 → a_out 3 (one step); steps=1; s_obs=3; err stays 0 (S7_CODE match).
- Target equal to the current model (e.g. 7 then 7) → no step_en cycles; done the next cycle; steps=0.
- Force s_obs=5 while model=1 → err=1 the next cycle and stays 1 through later requests until reset=0.
- MAX_STEPS=1, target 4 from 0 → one step (a=0, model=1), then err=1 and done; reset=0 mid-STEER of a later request returns req_ready=1, model=0, step_en=0 the next cycle.
